// File: rtl/laser_tx_pkg.sv
// Shared constants and FSM encoding for the laser transmit path.
// The echo capture side takes W_DATA from here as well.
package laser_tx_pkg;

    localparam int unsigned W_DATA     = 16;
    localparam int unsigned MAX_WORDS  = 4;
    localparam int unsigned MIN_PERIOD = 32;

    localparam int unsigned MAX_BITS = W_DATA * MAX_WORDS;
    localparam int unsigned W_WIDTH  = $clog2(MAX_BITS + 1);
    localparam int unsigned W_IDX    = $clog2(MAX_WORDS);
    localparam int unsigned LOG_W    = $clog2(W_DATA);
    localparam int unsigned W_PERIOD = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } tx_state_e;

endpackage

// File: rtl/pulse_word_gen.sv
// Combinational thermometer word: bit i is set when word_idx*W_DATA + i < width.
module pulse_word_gen
    import laser_tx_pkg::*;
(
    input  logic [W_IDX-1:0]   word_idx,
    input  logic [W_WIDTH-1:0] width,
    output logic [W_DATA-1:0]  word
);

    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < W_DATA; i++) begin
            word[i] = ((W_DATA * 32'(word_idx) + i) < 32'(width));
        end
    end

endmodule

// File: rtl/laser_pulse_tx.sv
// Laser pulse transmitter: one thermometer pulse per shot period as parallel TX words,
// with a send_en strobe marking the first word of each pulse.
module laser_pulse_tx
    import laser_tx_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                laser_enable,
    input  logic [W_PERIOD-1:0] period_cnt,
    input  logic [W_WIDTH-1:0]  pulse_width,
    output logic [W_DATA-1:0]   tx_datain,
    output logic                send_en,
    output logic                busy,
    output logic [15:0]         shot_cnt
);

    localparam logic [W_WIDTH-1:0]  MAX_BITS_W = W_WIDTH'(MAX_BITS);
    localparam logic [W_PERIOD-1:0] MIN_P      = W_PERIOD'(MIN_PERIOD);

    tx_state_e           state, state_next;
    logic [W_PERIOD-1:0] period_ctr;
    logic [W_PERIOD-1:0] period_last;
    logic [W_WIDTH-1:0]  width_q;
    logic [W_IDX-1:0]    word_idx;
    logic [W_IDX-1:0]    last_idx;
    logic                fire_entry;

    logic [W_WIDTH-1:0]  width_clip;
    logic [W_WIDTH:0]    word_cnt;
    logic [W_IDX-1:0]    last_idx_next;
    logic [W_PERIOD-1:0] period_last_next;
    logic [W_DATA-1:0]   word;

    // Shot parameters as they would be latched if FIRE were entered this cycle.
    always_comb begin
        width_clip       = (pulse_width > MAX_BITS_W) ? MAX_BITS_W : pulse_width;
        word_cnt         = ({1'b0, width_clip} + (W_WIDTH + 1)'(W_DATA - 1)) >> LOG_W;
        last_idx_next    = (word_cnt == '0) ? '0 : W_IDX'(word_cnt - (W_WIDTH + 1)'(1));
        period_last_next = (period_cnt < MIN_P) ? (MIN_P - W_PERIOD'(1))
                                                : (period_cnt - W_PERIOD'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (laser_enable) state_next = FIRE;
            FIRE:    if (word_idx == last_idx) state_next = WAIT;
            WAIT:    if (period_ctr == period_last) state_next = laser_enable ? FIRE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign fire_entry = (state_next == FIRE) && (state != FIRE);

    // Period counter restarts on every FIRE entry so shot starts are exactly one period apart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_ctr  <= '0;
            period_last <= '0;
            width_q     <= '0;
            word_idx    <= '0;
            last_idx    <= '0;
        end else if (fire_entry) begin
            period_ctr  <= '0;
            period_last <= period_last_next;
            width_q     <= width_clip;
            word_idx    <= '0;
            last_idx    <= last_idx_next;
        end else begin
            period_ctr <= (state == IDLE) ? '0 : period_ctr + W_PERIOD'(1);
            if (state == FIRE) word_idx <= word_idx + W_IDX'(1);
        end
    end

    pulse_word_gen u_word_gen (
        .word_idx (word_idx),
        .width    (width_q),
        .word     (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_datain <= '0;
            send_en   <= 1'b0;
            busy      <= 1'b0;
            shot_cnt  <= '0;
        end else begin
            tx_datain <= (state == FIRE) ? word : '0;
            send_en   <= (state == FIRE) && (word_idx == '0);
            busy      <= (state == FIRE);
            if ((state == FIRE) && (word_idx == '0)) shot_cnt <= shot_cnt + 16'd1;
        end
    end

endmodule
